// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmitter and receiver: line FSM state
// encoding, default bit timing and frame geometry.
// -----------------------------------------------------------------------------
package uart_pkg;

   // 81.25 MHz clock / 9600 baud
   localparam int DEFAULT_CLKS_PER_BIT = 8464;
   localparam int DATA_BITS            = 8;

   // Bit-period counter width; covers CLKS_PER_BIT up to 16383
   localparam int CNT_W = 14;
   localparam int IDX_W = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte write handshake into the transmitter. A byte is taken on a clock edge
// where data_in_en and data_in_rdy are both high.
//   data_in      byte to transmit          (master -> slave)
//   data_in_en   write strobe              (master -> slave)
//   data_in_rdy  transmit buffer not full  (slave  -> master)
// -----------------------------------------------------------------------------
interface uart_tx_if;

   logic [7:0] data_in;
   logic       data_in_en;
   logic       data_in_rdy;

   modport master (
      output data_in,
      output data_in_en,
      input  data_in_rdy
   );

   modport slave (
      input  data_in,
      input  data_in_en,
      output data_in_rdy
   );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Single-clock synchronous FIFO with a registered occupancy count. Read data
// is show-ahead: rd_data always presents the oldest entry.
//   clk, rst   clock, asynchronous active-high reset
//   wr_en      push request (ignored when full)
//   wr_data    data to push
//   rd_en      pop request (ignored when empty)
//   rd_data    oldest entry
//   count      number of entries held
//   full       count == DEPTH
//   empty      count == 0
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   assign rd_data = mem[rd_ptr];

   // NOTE: storage has no reset; only pointers and count are cleared, so the
   // array maps onto plain RAM/flops without a reset network.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // NOTE: non-blocking assignments throughout so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so pointer overflow is the modulo wrap
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Buffered 8N1 UART transmitter. Bytes written through the handshake are
// queued in uart_tx_fifo and sent LSB first, each bit lasting CLKS_PER_BIT
// clocks. Queued bytes go out back to back with no idle gap.
//   clk, rst    clock, asynchronous active-high reset
//   bus         byte write handshake (slave side)
//   tx          serial line, idle high, registered
//   busy        frame on the line or bytes queued
//   fifo_count  bytes currently buffered
// -----------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   uart_tx_if.slave                    bus,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   uart_state_t            state;
   uart_state_t            next_state;
   logic [CNT_W-1:0]       bit_cnt;
   logic [IDX_W-1:0]       bit_idx;
   logic [DATA_BITS-1:0]   shreg;
   logic [DATA_BITS-1:0]   fifo_rd_data;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   pop;
   logic                   bit_end;
   logic                   line_active;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (bus.data_in_en),
      .wr_data (bus.data_in),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.data_in_rdy = !fifo_full;

   assign bit_end = (state != IDLE) && (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));

   // tx and line_active follow the state one clock later, so busy must cover
   // both the state and the delayed line view to stay high until the stop
   // bit has actually left the pin.
   assign busy = line_active || (state != IDLE) || !fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               next_state = START;
               pop        = 1'b1;
            end
         end
         START: begin
            if (bit_end) next_state = DATA;
         end
         DATA: begin
            if (bit_end && (bit_idx == IDX_W'(DATA_BITS - 1))) next_state = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (!fifo_empty) begin
                  next_state = START;
                  pop        = 1'b1;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt     <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         tx          <= 1'b1;
         line_active <= 1'b0;
      end else begin
         if ((state == IDLE) || bit_end) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         if (pop) begin
            shreg <= fifo_rd_data;
         end else if ((state == DATA) && bit_end) begin
            shreg <= shreg >> 1;
         end

         if (state == DATA) begin
            if (bit_end) bit_idx <= bit_idx + 1'b1;
         end else begin
            bit_idx <= '0;
         end

         line_active <= (state != IDLE);

         case (state)
            START:   tx <= 1'b0;
            DATA:    tx <= shreg[0];
            default: tx <= 1'b1;
         endcase
      end
   end

endmodule
